fifo_write_arbiter: RTL

//  Shares the single write port of one fifo instance among NREQ requesters (console, disk, panel).

---
 rtl/fifo_arb_pkg.sv | 23 ++
 rtl/fifo_write_arbiter_rr_pick.sv | 28 ++
 rtl/fifo_write_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the fifo write-port arbiter.
package fifo_arb_pkg;

  // Arbiter FSM states; the encoding matches the busy flag.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  // Ceiling log2 for tools without $clog2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Round-robin picker: first requester after last_owner, wrapping mod NREQ.
module rr_pick #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned OW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [OW-1:0]   last_owner,
  output logic [OW-1:0]   pick,
  output logic            pick_valid
);

  logic [OW-1:0] idx;

  // Scan last_owner+1 .. last_owner+NREQ; index wraps mod NREQ, not mod 2^OW.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    idx        = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = OW'((32'(last_owner) + k) % NREQ);
      if (!pick_valid && req[idx]) begin
        pick       = idx;
        pick_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Shares one fifo write port among NREQ requesters with round-robin,
// burst-locked grants. ack/fifo_write/fifo_din are same-cycle outputs.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ       = 3,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            last,
  input  logic [NREQ*DATA_WIDTH-1:0] din_flat,
  output logic [NREQ-1:0]            ack,
  output logic [NREQ-1:0]            grant,
  output logic                       busy,
  output logic [DATA_WIDTH-1:0]      fifo_din,
  output logic                       fifo_write,
  input  logic                       fifo_full
);

  localparam int unsigned OW = clog2(NREQ);
  localparam int unsigned CW = clog2(MAX_BURST + 1);

  arb_state_e      state_q;
  logic [OW-1:0]   owner_q;
  logic [OW-1:0]   last_owner_q;
  logic [CW-1:0]   burst_cnt_q;
  logic [CW-1:0]   burst_cnt_d;
  logic [NREQ-1:0] grant_q;
  logic            busy_q;

  logic [OW-1:0]         pick;
  logic                  pick_valid;
  logic [DATA_WIDTH-1:0] din_arr [NREQ];
  logic                  owner_req;
  logic                  owner_last;
  logic                  wr_c;
  logic                  end_burst_c;

  // Unpack the flat data bus into per-requester words.
  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign din_arr[g] = din_flat[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(
    .NREQ (NREQ),
    .OW   (OW)
  ) u_rr_pick (
    .req        (req),
    .last_owner (last_owner_q),
    .pick       (pick),
    .pick_valid (pick_valid)
  );

  // Owner write path; reset suppresses any write so an abandoned burst leaves no partial word.
  always_comb begin
    owner_req   = req[owner_q];
    owner_last  = last[owner_q];
    wr_c        = reset_n && (state_q == ST_BURST) && owner_req && !fifo_full;
    burst_cnt_d = burst_cnt_q + CW'(1);
    end_burst_c = (state_q == ST_BURST) &&
                  (!owner_req || (wr_c && (owner_last || (burst_cnt_d == CW'(MAX_BURST)))));
    fifo_din    = din_arr[owner_q];
    fifo_write  = wr_c;
    ack         = wr_c ? (NREQ'(1) << owner_q) : '0;
  end

  // Arbiter FSM: grant on arbitration, hold through full stalls, release on last/max/drop.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_owner_q <= OW'(NREQ - 1);
      burst_cnt_q  <= '0;
      grant_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            state_q     <= ST_BURST;
            owner_q     <= pick;
            grant_q     <= NREQ'(1) << pick;
            burst_cnt_q <= '0;
            busy_q      <= 1'b1;
          end
        end
        ST_BURST: begin
          if (wr_c) begin
            burst_cnt_q <= burst_cnt_d;
          end
          if (end_burst_c) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            busy_q       <= 1'b0;
            last_owner_q <= owner_q;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;

endmodule
